// File: rtl/ca_prng_arbiter.sv
// Cellular-automaton random-word generator shared by NREQ requesters through
// a round-robin arbiter; one fresh word per one-cycle grant pulse.
module ca_prng_arbiter #(
  parameter int unsigned N            = 32,
  parameter int unsigned NREQ         = 4,
  parameter logic [7:0]  RESET_RULE   = 8'd30,
  parameter logic [31:0] RESET_SEED   = 32'h0000_0001,
  parameter int unsigned RESET_WARMUP = 16,
  parameter int unsigned WARMUP_W     = 8,
  parameter int unsigned STRIDE       = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_load,
  input  logic [7:0]          cfg_rule,
  input  logic [N-1:0]        cfg_seed,
  input  logic [WARMUP_W-1:0] cfg_warmup,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     gnt,
  output logic [N-1:0]        rnd_data,
  output logic                busy
);

  localparam int unsigned PtrW = $clog2(NREQ);
  localparam int unsigned CntW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [N-1:0]        SeedInit   = N'(RESET_SEED);
  localparam logic [WARMUP_W-1:0] WarmInit   = WARMUP_W'(RESET_WARMUP);
  localparam logic [CntW-1:0]     StrideInit = CntW'(STRIDE - 1);
  localparam logic [PtrW:0]       NreqW      = (PtrW + 1)'(NREQ);

  typedef enum logic [1:0] {StWarmup, StServe, StStride} state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        ca_q, ca_d, ca_next;
  logic [7:0]          rule_q, rule_d;
  logic [WARMUP_W-1:0] wcnt_q, wcnt_d;
  logic [CntW-1:0]     scnt_q, scnt_d;
  logic [PtrW-1:0]     rr_q, rr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [N-1:0]        data_q, data_d;

  // Circular CA: neighbourhood {left=i+1, self, right=i-1} indexes the rule byte.
  for (genvar i = 0; i < N; i++) begin : g_cell
    localparam int unsigned Up = (i + 1) % N;
    localparam int unsigned Dn = (i + N - 1) % N;
    assign ca_next[i] = rule_q[{ca_q[Up], ca_q[i], ca_q[Dn]}];
  end

  // Round-robin pick: rotate eligible so rr_q sits at bit 0, take the lowest set bit.
  logic [NREQ-1:0] eligible, rotated, grant_vec;
  logic [PtrW-1:0] pick_off, pick_k, rr_next;
  logic [PtrW:0]   pick_sum;
  logic            found;

  always_comb begin
    eligible = req & ~gnt_q;
    rotated  = NREQ'({eligible, eligible} >> rr_q);
    found    = 1'b0;
    pick_off = '0;
    for (int unsigned o = 0; o < NREQ; o++) begin
      if (!found && rotated[o]) begin
        found    = 1'b1;
        pick_off = o[PtrW-1:0];
      end
    end
    pick_sum  = {1'b0, rr_q} + {1'b0, pick_off};
    pick_k    = (pick_sum >= NreqW) ? PtrW'(pick_sum - NreqW) : PtrW'(pick_sum);
    rr_next   = ({1'b0, pick_k} == NreqW - (PtrW + 1)'(1)) ? '0 : pick_k + PtrW'(1);
    grant_vec = NREQ'(1) << pick_k;
  end

  always_comb begin
    state_d = state_q;
    ca_d    = ca_q;
    rule_d  = rule_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    data_d  = data_q;
    if (cfg_load) begin
      ca_d    = cfg_seed;
      rule_d  = cfg_rule;
      wcnt_d  = cfg_warmup;
      state_d = StWarmup;
    end else begin
      unique case (state_q)
        StWarmup: begin
          if (wcnt_q == '0) begin
            state_d = StServe;
          end else begin
            ca_d   = ca_next;
            wcnt_d = wcnt_q - WARMUP_W'(1);
          end
        end
        StServe: begin
          if (found) begin
            gnt_d  = grant_vec;
            data_d = ca_q;
            ca_d   = ca_next;
            rr_d   = rr_next;
            if (STRIDE > 1) begin
              state_d = StStride;
              scnt_d  = StrideInit;
            end
          end
        end
        StStride: begin
          ca_d   = ca_next;
          scnt_d = scnt_q - CntW'(1);
          if (scnt_q == CntW'(1)) state_d = StServe;
        end
        default: state_d = StWarmup;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWarmup;
      ca_q    <= SeedInit;
      rule_q  <= RESET_RULE;
      wcnt_q  <= WarmInit;
      scnt_q  <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ca_q    <= ca_d;
      rule_q  <= rule_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
    end
  end

  assign gnt      = gnt_q;
  assign rnd_data = data_q;
  assign busy     = (state_q != StServe);

endmodule
